// File: rtl/pueo_trig_pattern_gen.sv
// Trigger pattern generator: replays queued or periodic SURF trigger words once per frame,
// presenting each frame as a one-cycle registered valid burst VALID_DLY cycles after the phase pulse.
module pueo_trig_pattern_gen #(
    parameter int NSURF     = 32,
    parameter int NBIT      = 16,
    parameter int VALID_DLY = 3,
    parameter int DEPTH     = 16,
    localparam int SB       = $clog2(NSURF),
    localparam int CMDW     = NBIT + SB + 1
) (
    input  logic                    sysclk_i,
    input  logic                    sysclk_rstn_i,
    input  logic                    sysclk_phase_i,
    input  logic [1:0]              mode_i,
    input  logic [7:0]              period_i,
    input  logic [CMDW-1:0]         cmd_tdata,
    input  logic                    cmd_tvalid,
    output logic                    cmd_tready,
    output logic [NSURF*NBIT-1:0]   trig_dat_o,
    output logic                    trig_dat_valid_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic                    overrun_o,
    output logic [31:0]             frame_count_o,
    output logic [15:0]             trig_count_o,
    output logic [7:0]              bad_cmd_count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int W  = NSURF * NBIT;

    logic [CMDW-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     fill;
    logic            push, pop, rep, sel_act, sel_bad, sel_ok;
    logic [CMDW-1:0] head, sel_cmd, last_cmd, lat_cmd, fire_cmd;
    logic            have_last, lat_ok, fire_ok, fire;
    logic [7:0]      per_cnt, per_reload;
    logic [3:0]      dly_cnt;
    logic [W-1:0]    fire_dat;

    assign empty_o    = (fill == '0);
    assign full_o     = (fill == (AW+1)'(DEPTH));
    assign cmd_tready = !full_o;
    assign head       = mem[rd_ptr];
    assign per_reload = (period_i == 8'd0) ? 8'd0 : period_i - 8'd1;

    always_comb begin
        push     = cmd_tvalid && !full_o;
        pop      = sysclk_phase_i && !mode_i[1] && !empty_o;
        rep      = sysclk_phase_i && (mode_i == 2'b01) && empty_o && have_last && (per_cnt == 8'd0);
        sel_act  = pop || rep;
        sel_cmd  = pop ? head : last_cmd;
        sel_bad  = sel_act && !sel_cmd[CMDW-1] && (int'(sel_cmd[NBIT +: SB]) >= NSURF);
        sel_ok   = sel_act && !sel_bad;
        // With a one-cycle delay the frame goes straight to the output register at the phase edge.
        if (VALID_DLY == 1) begin
            fire     = sysclk_phase_i;
            fire_cmd = sel_cmd;
            fire_ok  = sel_ok;
        end else begin
            fire     = !sysclk_phase_i && (dly_cnt == 4'd1);
            fire_cmd = lat_cmd;
            fire_ok  = lat_ok;
        end
        fire_dat = '0;
        if (fire_ok) begin
            for (int n = 0; n < NSURF; n++) begin
                if (fire_cmd[CMDW-1] || (int'(fire_cmd[NBIT +: SB]) == n)) begin
                    fire_dat[n*NBIT +: NBIT] = fire_cmd[NBIT-1:0];
                end
            end
        end
    end

    always_ff @(posedge sysclk_i) begin
        if (push) begin
            mem[wr_ptr] <= cmd_tdata;
        end
    end

    always_ff @(posedge sysclk_i) begin
        if (!sysclk_rstn_i) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            fill             <= '0;
            last_cmd         <= '0;
            have_last        <= 1'b0;
            lat_cmd          <= '0;
            lat_ok           <= 1'b0;
            per_cnt          <= '0;
            dly_cnt          <= '0;
            overrun_o        <= 1'b0;
            trig_dat_valid_o <= 1'b0;
            trig_dat_o       <= '0;
            frame_count_o    <= '0;
            trig_count_o     <= '0;
            bad_cmd_count_o  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                last_cmd  <= head;
                have_last <= 1'b1;
            end
            if (push && !pop) begin
                fill <= fill + (AW+1)'(1);
            end else if (pop && !push) begin
                fill <= fill - (AW+1)'(1);
            end

            if (sysclk_phase_i) begin
                frame_count_o <= frame_count_o + 32'd1;
                lat_cmd       <= sel_cmd;
                lat_ok        <= sel_ok;
                if (sel_act) begin
                    per_cnt <= per_reload;
                end else if (per_cnt != 8'd0) begin
                    per_cnt <= per_cnt - 8'd1;
                end
                if (sel_bad && (bad_cmd_count_o != 8'hFF)) begin
                    bad_cmd_count_o <= bad_cmd_count_o + 8'd1;
                end
                // A frame still counting down is dropped in favour of the new one.
                if (dly_cnt != 4'd0) begin
                    overrun_o <= 1'b1;
                end
                dly_cnt <= 4'(VALID_DLY - 1);
            end else if (dly_cnt != 4'd0) begin
                dly_cnt <= dly_cnt - 4'd1;
            end

            trig_dat_valid_o <= fire;
            trig_dat_o       <= fire ? fire_dat : '0;
            if (fire && (fire_dat != '0)) begin
                trig_count_o <= trig_count_o + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pueo_trig_pattern_gen.sv
// Bench for pueo_trig_pattern_gen: queue-based frame model checked every cycle, plus directed scenarios.
module tb_pueo_trig_pattern_gen;
    localparam int NSURF = 32, NBIT = 16, DEPTH = 16, VALID_DLY = 3;
    localparam int CMDW = 22, CMDW2 = 23, W = NSURF * NBIT, W2 = 40 * NBIT;

    logic clk = 1'b0, rstn = 1'b0, phase = 1'b0, tvalid = 1'b0, d2_tvalid = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] period = 8'd0;
    logic [CMDW-1:0] tdata = '0;
    logic [CMDW2-1:0] d2_tdata = '0;

    logic tready, valid, empty, full, overrun;
    logic [W-1:0] dat;
    logic [31:0] frame_count;
    logic [15:0] trig_count;
    logic [7:0] bad_count;

    logic d2_tready, d2_valid, d2_empty, d2_full, d2_overrun;
    logic [W2-1:0] d2_dat;
    logic [31:0] d2_frame_count;
    logic [15:0] d2_trig_count;
    logic [7:0] d2_bad_count;

    pueo_trig_pattern_gen dut (
        .sysclk_i(clk), .sysclk_rstn_i(rstn), .sysclk_phase_i(phase), .mode_i(mode),
        .period_i(period), .cmd_tdata(tdata), .cmd_tvalid(tvalid), .cmd_tready(tready),
        .trig_dat_o(dat), .trig_dat_valid_o(valid), .empty_o(empty), .full_o(full),
        .overrun_o(overrun), .frame_count_o(frame_count), .trig_count_o(trig_count),
        .bad_cmd_count_o(bad_count)
    );

    pueo_trig_pattern_gen #(.NSURF(40)) dut2 (
        .sysclk_i(clk), .sysclk_rstn_i(rstn), .sysclk_phase_i(phase), .mode_i(mode),
        .period_i(period), .cmd_tdata(d2_tdata), .cmd_tvalid(d2_tvalid), .cmd_tready(d2_tready),
        .trig_dat_o(d2_dat), .trig_dat_valid_o(d2_valid), .empty_o(d2_empty), .full_o(d2_full),
        .overrun_o(d2_overrun), .frame_count_o(d2_frame_count), .trig_count_o(d2_trig_count),
        .bad_cmd_count_o(d2_bad_count)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [CMDW-1:0] mk(input logic b, input int idx, input logic [15:0] w);
        return {b, 5'(idx), w};
    endfunction

    function automatic logic [W-1:0] slot(input int idx, input logic [15:0] w);
        logic [W-1:0] r;
        r = '0;
        r[idx*NBIT +: NBIT] = w;
        return r;
    endfunction

    // Frame model: FIFO as a queue, frames scheduled by absolute cycle number.
    logic [CMDW-1:0] mq[$];
    logic [CMDW-1:0] m_last = '0, m_c;
    logic m_have_last = 1'b0, m_pend = 1'b0, m_valid = 1'b0, m_over = 1'b0, m_act, m_acc;
    logic [W-1:0] m_pdat = '0, m_dat = '0, m_fr;
    logic [31:0] m_frames = 0;
    logic [15:0] m_trig = 0;
    logic [7:0] m_bad = 0;
    int m_fs = 0, m_due = 0, cyc = 0, m_idx, m_per;

    always @(posedge clk) begin
        if (!rstn) begin
            mq.delete();
            m_have_last = 0; m_pend = 0; m_valid = 0; m_over = 0; m_dat = '0;
            m_frames = 0; m_trig = 0; m_bad = 0; m_fs = 0;
        end else begin
            cyc++;
            m_acc = tvalid && (mq.size() < DEPTH);
            m_valid = 0;
            m_dat = '0;
            if (phase) begin
                m_frames++;
                m_act = 0;
                m_c = '0;
                m_per = (period == 0) ? 1 : int'(period);
                if (mode < 2 && mq.size() > 0) begin
                    m_c = mq.pop_front();
                    m_last = m_c; m_have_last = 1; m_act = 1; m_fs = 0;
                end else begin
                    m_fs++;
                    if (mode == 1 && m_have_last && m_fs >= m_per) begin
                        m_c = m_last; m_act = 1; m_fs = 0;
                    end
                end
                m_fr = '0;
                m_idx = int'(m_c[20:16]);
                if (m_act) begin
                    if (m_c[CMDW-1]) begin
                        for (int n = 0; n < NSURF; n++) m_fr[n*NBIT +: NBIT] = m_c[15:0];
                    end else if (m_idx < NSURF) begin
                        m_fr = slot(m_idx, m_c[15:0]);
                    end else if (m_bad != 8'hFF) begin
                        m_bad++;
                    end
                end
                if (m_pend) m_over = 1;
                m_pend = 1;
                m_due = cyc + VALID_DLY - 1;
                m_pdat = m_fr;
            end
            if (m_acc) mq.push_back(tdata);
            if (m_pend && m_due == cyc) begin
                m_valid = 1; m_dat = m_pdat; m_pend = 0;
                if (m_pdat != '0) m_trig++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", valid, m_valid);
            chk("data", dat, m_dat);
            chk("empty", empty, mq.size() == 0);
            chk("full", full, mq.size() == DEPTH);
            chk("tready", tready, mq.size() < DEPTH);
            chk("overrun", overrun, m_over);
            chk("frame_count", frame_count, m_frames);
            chk("trig_count", trig_count, m_trig);
            chk("bad_count", bad_count, m_bad);
        end
    end

    task automatic push(input logic [CMDW-1:0] c);
        tvalid = 1; tdata = c;
        @(negedge clk);
        tvalid = 0;
    endtask

    task automatic frame(output logic v, output logic [W-1:0] d);
        phase = 1;
        @(negedge clk);
        phase = 0;
        @(negedge clk);
        @(negedge clk);
        v = valid; d = dat;
    endtask

    logic v;
    logic [W-1:0] d, bc;
    logic [11:0] nzmask;
    int npulse;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_tready", tready, 1);
        chk("rst_overrun", overrun, 0);
        chk("rst_valid", valid, 0);
        chk("rst_data", dat, 0);
        chk("rst_frames", frame_count, 0);
        chk_en = 1;
        rstn = 1;
        @(negedge clk);

        // single push, slot 5
        push(mk(0, 5, 16'hBEEF));
        phase = 1;
        @(negedge clk);
        phase = 0;
        chk("t1_novalid", valid, 0);
        @(negedge clk);
        chk("t2_novalid", valid, 0);
        @(negedge clk);
        chk("t3_valid", valid, 1);
        chk("t3_slot5", dat[5*NBIT +: NBIT], 16'hBEEF);
        chk("t3_others", dat & ~slot(5, 16'hFFFF), 0);
        chk("t3_trig", trig_count, 1);
        repeat (2) @(negedge clk);

        // fill to full, then drain in order
        for (int i = 0; i < 16; i++) push(mk(0, i, 16'hA000 + 16'(i)));
        chk("fill_full", full, 1);
        chk("fill_tready", tready, 0);
        for (int i = 0; i < 16; i++) begin
            frame(v, d);
            chk("drain_valid", v, 1);
            chk("drain_data", d, slot(i, 16'hA000 + 16'(i)));
        end
        chk("drain_empty", empty, 1);

        // push and pop in the same cycle
        push(mk(0, 3, 16'h0333));
        tvalid = 1; tdata = mk(0, 4, 16'h0444); phase = 1;
        @(negedge clk);
        tvalid = 0; phase = 0;
        chk("pp_occupied", empty, 0);
        repeat (2) @(negedge clk);
        chk("pp_first", dat, slot(3, 16'h0333));
        frame(v, d);
        chk("pp_second", d, slot(4, 16'h0444));
        chk("pp_empty", empty, 1);

        // periodic broadcast, period 4
        mode = 2'b01; period = 8'd4;
        push(mk(1, 0, 16'h0001));
        bc = '0;
        for (int n = 0; n < NSURF; n++) bc[n*NBIT +: NBIT] = 16'h0001;
        nzmask = '0; npulse = 0;
        for (int i = 0; i < 12; i++) begin
            frame(v, d);
            if (v) npulse++;
            if (v && d != '0) nzmask[i] = 1;
            if (i == 0) chk("per_bcast", d, bc);
        end
        chk("per_mask", nzmask, 12'h111);
        chk("per_pulses", npulse, 12);

        // out-of-range index on the 40-slot instance
        mode = 2'b00;
        chk("bad_before", d2_bad_count, 0);
        d2_tvalid = 1; d2_tdata = {1'b0, 6'd40, 16'h1234};
        @(negedge clk);
        d2_tvalid = 0;
        frame(v, d);
        chk("bad_valid", d2_valid, 1);
        chk("bad_zero", d2_dat == '0, 1);
        chk("bad_count", d2_bad_count, 1);
        chk("bad_trig", d2_trig_count, 0);

        // hold modes keep the FIFO untouched
        for (int m = 2; m < 4; m++) begin
            mode = 2'(m);
            push(mk(0, m, 16'h0C00 + 16'(m)));
            frame(v, d);
            chk("hold_valid", v, 1);
            chk("hold_zero", d, 0);
            chk("hold_kept", empty, 0);
        end
        mode = 2'b00;
        frame(v, d);
        chk("hold_pop1", d, slot(2, 16'h0C02));
        frame(v, d);
        chk("hold_pop2", d, slot(3, 16'h0C03));

        // phase pulses two cycles apart
        push(mk(0, 1, 16'h1111));
        push(mk(0, 2, 16'h2222));
        chk("ovr_clear", overrun, 0);
        phase = 1; @(negedge clk); phase = 0; @(negedge clk);
        phase = 1; @(negedge clk); phase = 0;
        npulse = 0; d = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (valid) begin npulse++; d = dat; end
        end
        chk("ovr_pulses", npulse, 1);
        chk("ovr_data", d, slot(2, 16'h2222));
        chk("ovr_flag", overrun, 1);

        // reset one cycle after a phase pulse
        for (int i = 0; i < 3; i++) push(mk(0, i, 16'h5500 + 16'(i)));
        phase = 1; @(negedge clk); phase = 0;
        rstn = 0; @(negedge clk); rstn = 1;
        npulse = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (valid) npulse++;
        end
        chk("rstmid_pulses", npulse, 0);
        chk("rstmid_empty", empty, 1);
        chk("rstmid_frames", frame_count, 0);
        chk("rstmid_trig", trig_count, 0);
        chk("rstmid_bad", d2_bad_count, 0);
        chk("rstmid_overrun", overrun, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pueo_trig_pattern_gen.md
PUEO_TRIG_PATTERN_GEN -- requirements
Module: pueo_trig_pattern_gen

Interface
REQ-001 The block SHALL have parameter NSURF, default 32, meaning number of SURF trigger slots.
REQ-002 The block SHALL have parameter NBIT, default 16, meaning trigger word width per SURF.
REQ-003 The block SHALL have parameter VALID_DLY, default 3, meaning cycles from phase pulse to valid (legal range 1-8).
REQ-004 The block SHALL have parameter DEPTH, default 16, meaning command FIFO depth (power of 2, at least 2).
REQ-005 The block SHALL define SB = clog2(NSURF) and CMDW = NBIT+SB+1.
REQ-006 The block SHALL have the port sysclk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have the port sysclk_rstn_i, input, 1 bit: reset, synchronous and active-low.
REQ-008 The block SHALL have the port sysclk_phase_i, input, 1 bit: one-cycle frame-start pulse.
REQ-009 The block SHALL have the port mode_i, input, 2 bits: 00 FIFO, 01 periodic, 10 hold, 11 treated as hold.
REQ-010 The block SHALL have the port period_i, input, 8 bits: repeat interval in frames for periodic mode.
REQ-011 The block SHALL have the command ports cmd_tdata (input, CMDW bits), cmd_tvalid (input, 1 bit) and cmd_tready (output, 1 bit).
- cmd_tdata fields: [NBIT-1:0] word, [NBIT+SB-1:NBIT] SURF index, [CMDW-1] broadcast.
REQ-012 The block SHALL have the port trig_dat_o, output, NSURF*NBIT bits: trigger words; SURF n occupies bits [n*NBIT +: NBIT].
REQ-013 The block SHALL have the port trig_dat_valid_o, output, 1 bit: frame data valid.
REQ-014 The block SHALL have the status ports empty_o and full_o, outputs, 1 bit each: FIFO state.
REQ-015 The block SHALL have the status port overrun_o, output, 1 bit: sticky phase-overrun flag.
REQ-016 The block SHALL have the counter ports frame_count_o (output, 32 bits), trig_count_o (output, 16 bits) and bad_cmd_count_o (output, 8 bits).

Function
REQ-017 cmd_tready SHALL equal !full_o; a beat is accepted when cmd_tvalid && cmd_tready.
REQ-018 An accepted beat SHALL be eligible for pop at phase pulses from the following cycle onward.
- There is no same-cycle push-to-pop bypass.
REQ-019 Each sysclk_phase_i pulse SHALL start a frame, and frame_count_o SHALL increment, wrapping at 2^32.
REQ-020 At the phase pulse, FIFO mode with the FIFO non-empty SHALL pop exactly one entry into the frame latch; an empty FIFO SHALL leave a zero frame.
REQ-021 Periodic mode SHALL pop like FIFO mode when non-empty.
- When empty, it re-emits the last popped command on every period_i-th frame since the last emission.
- period_i = 0 is treated as 1.
- If no command has been popped since reset, it emits zero frames.
REQ-022 Hold mode SHALL NOT pop and SHALL emit zero frames; the FIFO contents are retained.
REQ-023 trig_dat_valid_o SHALL pulse high for exactly one cycle, VALID_DLY cycles after each phase pulse, for every frame, including zero frames.
REQ-024 trig_dat_o SHALL be registered, carry the frame data only in the valid cycle, and be all-zero in every other cycle.
REQ-025 Frame data SHALL be formed as follows:
- broadcast=1 places word in all NSURF slots;
- otherwise word is placed in the indexed slot and all other slots are zero.
REQ-026 trig_count_o SHALL increment (wrapping) on every valid cycle that carries non-zero data.
REQ-027 A non-broadcast command with index >= NSURF SHALL emit a zero frame and increment bad_cmd_count_o, saturating at 255.
REQ-028 A phase pulse arriving while a previous frame is still before its valid cycle SHALL supersede it.
- The older frame's valid pulse is suppressed.
- overrun_o is set sticky until reset.
REQ-029 A push and a pop in the same cycle SHALL both complete, and the occupancy SHALL be unchanged.
REQ-030 The FIFO SHALL wrap its pointers modulo DEPTH with no data loss.
- full_o is asserted at DEPTH entries; empty_o is asserted at 0 entries.
REQ-031 A change of mode_i SHALL take effect at the next phase pulse.

Reset
REQ-032 While sysclk_rstn_i is low at a clock edge, the block SHALL clear the FIFO, the frame latch, the delay pipeline, the last-command register, the period counter and all counters.
- Resulting outputs: empty_o=1, full_o=0, cmd_tready=1, overrun_o=0, trig_dat_valid_o=0, trig_dat_o=0.
REQ-033 A reset asserted mid-frame SHALL cancel the pending valid pulse, and no pulse SHALL appear after reset is released.

Verification
REQ-034 The bench SHALL cover a single push with index 5, word 0xBEEF in FIFO mode followed by a phase pulse at cycle t.
- Required response: valid at t+3, slot 5 = 0xBEEF, other slots 0, trig_count_o=1.
REQ-035 The bench SHALL cover 16 pushes with no phase pulses.
- Required response: full_o=1, cmd_tready=0.
- 16 subsequent phase pulses emit the entries in push order, then empty_o=1.
REQ-036 The bench SHALL cover a broadcast push with word 0x0001 in periodic mode with period_i=4 and 12 phase pulses.
- Required response: non-zero frames 1, 5, 9 (all 32 slots = 0x0001); the other 9 frames are zero with valid still pulsing.
REQ-037 The bench SHALL cover a push with index 40.
- Required response: zero frame, bad_cmd_count_o=1, trig_count_o unchanged.
REQ-038 The bench SHALL cover phase pulses 2 cycles apart.
- Required response: only the second frame's valid appears, and overrun_o=1.
REQ-039 The bench SHALL cover a reset asserted 1 cycle after a phase pulse with the FIFO holding 3 entries.
- Required response: no valid pulse, empty_o=1, all counters 0.
